// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-unit types (fsm states, fetch entry) and constants.
package ifu_pkg;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with push/pop/flush; push and pop may coincide when full.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC, imem request/response tracking and in-order prefetch queue for decode.
// Define IFU_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stop,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_insn_vld,
  output logic [XLEN-1:0] o_insn,
  output logic [XLEN-1:0] o_insn_pc,
  input  logic            i_insn_rdy,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_misalign,
  output logic            o_busy
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } entry_t;
  state_t state, state_nx;
  logic [XLEN-1:0] fetch_pc, tag_pc;
  logic [CW-1:0] drop, outst, q_count, t_count, credits;
  logic gnt_fire, rsp_keep, byp, q_push, q_pop, q_empty, q_full, t_full, t_empty;
  entry_t q_head;
  // live tags plus pending drops account for every request still owed a response
  assign outst = t_count + drop;
  assign credits = CW'(DEPTH) - q_count - outst;
  assign o_imem_req = (state == S_RUN) & ~i_stop & (credits != '0);
  assign o_imem_addr = fetch_pc;
  assign gnt_fire = o_imem_req & i_imem_gnt;
  assign rsp_keep = i_imem_rvalid & (drop == '0) & ~i_redirect;
  assign o_busy = outst != '0;
`ifdef IFU_BYPASS_EN
  assign byp = rsp_keep & q_empty;
`else
  assign byp = 1'b0;
`endif
  assign q_push = rsp_keep & ~(byp & i_insn_rdy);
  assign q_pop = ~q_empty & i_insn_rdy & ~i_redirect;
  assign o_insn_vld = ~q_empty | byp;
  assign o_insn = ~q_empty ? q_head.insn : byp ? i_imem_rdata : '0;
  assign o_insn_pc = ~q_empty ? q_head.pc : byp ? tag_pc : '0;
  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(i_clk), .rst(i_rst), .push(gnt_fire), .pop(rsp_keep), .flush(i_redirect),
    .wdata(fetch_pc), .rdata(tag_pc), .count(t_count), .full(t_full), .empty(t_empty)
  );
  ifu_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(i_clk), .rst(i_rst), .push(q_push), .pop(q_pop), .flush(i_redirect),
    .wdata({tag_pc, i_imem_rdata}), .rdata(q_head), .count(q_count), .full(q_full), .empty(q_empty)
  );
  always_comb state_nx = state == S_BOOT ? S_RUN : i_stop ? S_HALT : S_RUN;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_BOOT;
      fetch_pc <= RESET_PC;
      drop <= '0;
      o_misalign <= 1'b0;
    end else begin
      state <= state_nx;
      fetch_pc <= i_redirect ? {i_redirect_pc[XLEN-1:2], 2'b00} : gnt_fire ? fetch_pc + XLEN'(4) : fetch_pc;
      drop <= i_redirect ? outst + CW'(gnt_fire) - CW'(i_imem_rvalid) : drop - CW'(i_imem_rvalid && drop != '0);
      o_misalign <= i_redirect & |i_redirect_pc[1:0];
    end
  always_ff @(posedge i_clk)
    if (!i_rst) assert (!(t_full && gnt_fire && !i_redirect) && !(t_empty && rsp_keep) && !(q_full && q_push && !q_pop));
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: scoreboard bench; imem model with variable in-order latency, model of fetch PC.
module tb_ifu_prefetch;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk, i_rst, i_stop, o_imem_req, i_imem_gnt, i_imem_rvalid, o_insn_vld, i_insn_rdy;
  logic i_redirect, o_misalign, o_busy;
  logic [31:0] o_imem_addr, i_imem_rdata, o_insn, o_insn_pc, i_redirect_pc;
  int n_chk = 0, n_ok = 0, n_gnt = 0, n_pop = 0, cyc = 0, lat = 1, last_due = 0;
  logic [31:0] exp_pc, e;
  logic mis_q;
  logic [31:0] mq[$];
  int md[$];
  logic [31:0] sb[$];

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stop(i_stop), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_insn_vld(o_insn_vld), .o_insn(o_insn), .o_insn_pc(o_insn_pc), .i_insn_rdy(i_insn_rdy),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_misalign(o_misalign), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one cycle: inputs already driven after a negedge; checks, then advance and drive imem response
  task automatic tick();
    logic fire;
    logic [31:0] p;
    #1;
    fire = o_imem_req & i_imem_gnt;
    check("busy", o_busy, (mq.size() != 0) | i_imem_rvalid);
    check("misalign", o_misalign, mis_q);
    if (i_stop) check("stop_req", o_imem_req, 0);
    if (fire) begin
      check("req_addr", o_imem_addr, exp_pc);
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back(exp_pc);
      md.push_back(last_due);
      n_gnt++;
    end
    if (i_redirect) sb.delete();
    else begin
      if (o_insn_vld && i_insn_rdy) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          p = sb.pop_front();
          check("insn_pc", o_insn_pc, p);
          check("insn", o_insn, insn_of(p));
          n_pop++;
        end
      end
      if (fire) sb.push_back(exp_pc);
    end
    mis_q = i_redirect & |i_redirect_pc[1:0];
    exp_pc = i_redirect ? {i_redirect_pc[31:2], 2'b00} : fire ? exp_pc + 32'd4 : exp_pc;
    @(negedge clk);
    cyc++;
    i_redirect = 1'b0;
    if (mq.size() != 0 && md[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata = insn_of(mq.pop_front());
      void'(md.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_stop = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    mq.delete();
    md.delete();
    sb.delete();
    exp_pc = RESET_PC;
    mis_q = 1'b0;
    last_due = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", o_imem_req, 0);
    check("rst_addr", o_imem_addr, RESET_PC);
    check("rst_vld", o_insn_vld, 0);
    check("rst_insn", o_insn, 0);
    check("rst_pc", o_insn_pc, 0);
    check("rst_misalign", o_misalign, 0);
    check("rst_busy", o_busy, 0);
    i_rst = 1'b0;
  endtask

  initial begin
    int p0;
    i_imem_gnt = 1'b1;
    i_insn_rdy = 1'b1;
    lat = 1;
    do_reset();
    check("boot_req", o_imem_req, 0);
    tick();
    #1;
    check("run_req", o_imem_req, 1);
    check("run_addr", o_imem_addr, RESET_PC);
    repeat (6) tick();
    p0 = n_pop;
    repeat (10) tick();
    check("throughput", n_pop - p0, 10);

    i_insn_rdy = 1'b0;
    do_reset();
    p0 = n_gnt;
    repeat (12) tick();
    #1;
    check("cap_grants", n_gnt - p0, DEPTH);
    check("cap_req", o_imem_req, 0);
    check("cap_vld", o_insn_vld, 1);
    i_insn_rdy = 1'b1;
    #1;
    check("req_at_pop", o_imem_req, 0);
    tick();
    #1;
    check("resume_req", o_imem_req, 1);
    repeat (8) tick();

    lat = 3;
    repeat (10) tick();
    #1;
    check("busy_pre_redir", o_busy, 1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    #1;
    check("redir_addr", o_imem_addr, 32'h100);
    repeat (15) tick();

    i_redirect = 1'b1;
    i_redirect_pc = 32'h102;
    tick();
    #1;
    check("mis_pulse", o_misalign, 1);
    check("mis_addr", o_imem_addr, 32'h100);
    repeat (8) tick();

    lat = 2;
    repeat (6) tick();
    i_stop = 1'b1;
    repeat (20) begin
      #1;
      if (!o_busy && !o_insn_vld) break;
      tick();
    end
    check("stop_busy", o_busy, 0);
    check("stop_vld", o_insn_vld, 0);
    i_stop = 1'b0;
    e = exp_pc;
    repeat (5) begin
      #1;
      if (o_imem_req) break;
      tick();
    end
    check("stop_resume_req", o_imem_req, 1);
    check("stop_resume_pc", o_imem_addr, e);
    repeat (6) tick();

    lat = 1;
    repeat (6) tick();
    #1;
    check("pre_rvalid", i_imem_rvalid, 1);
    check("pre_vld", o_insn_vld, 1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    tick();
    #1;
    check("redir_flush_vld", o_insn_vld, 0);
    repeat (6) tick();

    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    repeat (400) begin
      i_imem_gnt = ($urandom % 4) != 0;
      i_insn_rdy = ($urandom % 3) != 0;
      lat = 1 + ($urandom % 4);
      i_stop = ($urandom % 8) == 0;
      if (($urandom % 20) == 0) begin
        i_redirect = 1'b1;
        i_redirect_pc = $urandom;
      end
      tick();
    end
    i_stop = 1'b1;
    i_insn_rdy = 1'b1;
    repeat (40) begin
      #1;
      if (!o_busy && !o_insn_vld) break;
      tick();
    end
    check("drain_busy", o_busy, 0);
    check("drain_sb", sb.size(), 0);

    i_stop = 1'b0;
    i_imem_gnt = 1'b1;
    lat = 2;
    repeat (8) tick();
    do_reset();
    check("mid_boot_req", o_imem_req, 0);
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
